// File: rtl/arb_pkt_mux.sv
// Packet mux around an external round-robin arbiter: locks the grant for a whole packet and
// forwards beats through a registered valid/ready stage. Define ARB_PKT_MUX_B2B_EN for back-to-back packets.
module arb_pkt_mux #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    req_o,
    input  logic [N-1:0]    gnt_i,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [SW-1:0] out_src_q, out_src_d;

    logic [N-1:0]  ready_vec;
    logic          accept;
    logic          gnt_onehot;
    logic          gnt_ok;
    logic [SW-1:0] gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_i[i]) begin
                gnt_idx = SW'(i);
            end
        end
    end

    // A grant is only honoured if it is one-hot and lands on a bit we are actually requesting.
    assign gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - 1'b1)) == '0);
    assign gnt_ok     = gnt_onehot && ((gnt_i & ~req_o) == '0);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        req_o       = '0;
        ready_vec   = '0;
        accept      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                req_o = in_valid;
                if (gnt_ok) begin
                    owner_d = gnt_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                ready_vec[owner_q] = ~out_valid_q | out_ready;
                accept             = in_valid[owner_q] & ready_vec[owner_q];
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data[int'(owner_q)*DW +: DW];
                    out_last_d  = in_last[owner_q];
                    out_src_d   = owner_q;
                    if (in_last[owner_q]) begin
                        state_d = IDLE;
`ifdef ARB_PKT_MUX_B2B_EN
                        // Hand the lock straight to another requester; the owner itself is masked out.
                        req_o          = in_valid;
                        req_o[owner_q] = 1'b0;
                        if (gnt_ok) begin
                            owner_d = gnt_idx;
                            state_d = LOCKED;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    // A grant that is not one-hot or targets a non-requesting port is ignored; flag it in simulation.
    always_ff @(posedge clk) begin
        if (reset && (gnt_i != '0)) begin
            assert (gnt_ok);
        end
    end

    assign in_ready  = ready_vec;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Scoreboard bench for arb_pkt_mux with a fixed-priority (lowest index) arbiter model.
module tb_arb_pkt_mux;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    req_o;
    logic [N-1:0]    gnt_i;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            out_ready;

    logic            vld [N];
    logic [DW-1:0]   dat [N];
    logic            lst [N];
    logic            arbEn;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t expQ[$];
    int    total;
    int    bad;
    logic  heldValid;
    logic [63:0] heldWord;

    arb_pkt_mux #(.N(N), .DW(DW)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .req_o(req_o),
        .gnt_i(gnt_i),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_src(out_src),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_valid[i]          = vld[i];
            in_data[i*DW +: DW]  = dat[i];
            in_last[i]           = lst[i];
        end
    end

    assign gnt_i = arbEn ? (req_o & (~req_o + 4'd1)) : 4'd0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpected(input int p, input logic [DW-1:0] base, input int n);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.src  = SW'(p);
            e.data = base + DW'(b);
            e.last = (b == n - 1);
            expQ.push_back(e);
        end
    endtask

    // Drives one packet on port p; optionally drops valid for stallCycles after beat stallAfter.
    task automatic applyStimulus(input int p, input logic [DW-1:0] base, input int n,
                                 input int stallAfter, input int stallCycles);
        int waitCnt;
        for (int b = 0; b < n; b++) begin
            vld[p] = 1'b1;
            dat[p] = base + DW'(b);
            lst[p] = (b == n - 1);
            waitCnt = 0;
            @(negedge clk);
            while (!in_ready[p] && waitCnt < 200) begin
                waitCnt++;
                @(negedge clk);
            end
            if (waitCnt >= 200) begin
                total++;
                bad++;
                $display("[TB] FAIL wait_ready port %0d: got in_ready 0 expected 1 within 200 cycles", p);
                vld[p] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (b == stallAfter) begin
                vld[p] = 1'b0;
                repeat (stallCycles) @(posedge clk);
                #1;
            end
        end
        vld[p] = 1'b0;
        lst[p] = 1'b0;
    endtask

    task automatic monitorStep();
        beat_t e;
        if (!reset) begin
            heldValid = 1'b0;
            return;
        end
        if (heldValid) begin
            checkOutput("hold_stable", {29'd0, out_valid, out_last, out_src, out_data}, heldWord);
        end
        if (out_valid && !out_ready) begin
            heldValid = 1'b1;
            heldWord  = {29'd0, out_valid, out_last, out_src, out_data};
        end else begin
            heldValid = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h src %0d expected no beat", out_data, out_src);
            end else begin
                e = expQ.pop_front();
                checkOutput("beat_data", 64'(out_data), 64'(e.data));
                checkOutput("beat_src", 64'(out_src), 64'(e.src));
                checkOutput("beat_last", 64'(out_last), 64'(e.last));
            end
        end
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while ((expQ.size() != 0 || out_valid) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        heldValid = 1'b0;
        heldWord  = '0;
        arbEn     = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b1;
            dat[i] = 32'hDEAD_0000 + DW'(i);
            lst[i] = 1'b1;
        end

        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        // Reset with stale inputs, then one IDLE cycle with the arbiter muted.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_req", 64'(req_o), 64'h0F);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_out_data", 64'(out_data), 64'h0);
        checkOutput("rst_out_src", 64'(out_src), 64'h0);
        checkOutput("rst_out_last", 64'(out_last), 64'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            lst[i] = 1'b0;
        end
        arbEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single packet on port 2");
        pushExpected(2, 32'hA0, 3);
        fork
            applyStimulus(2, 32'hA0, 3, -1, 0);
            begin
                @(negedge clk);
                checkOutput("sp_req_idle", 64'(req_o), 64'h4);
                checkOutput("sp_ready_idle", 64'(in_ready), 64'h0);
                @(negedge clk);
                checkOutput("sp_req_locked", 64'(req_o), 64'h0);
                checkOutput("sp_ready_locked", 64'(in_ready), 64'h4);
                checkOutput("sp_valid_t1", 64'(out_valid), 64'h0);
                @(negedge clk);
                checkOutput("sp_valid_t2", 64'(out_valid), 64'h1);
                checkOutput("sp_data_t2", 64'(out_data), 64'hA0);
                checkOutput("sp_req_locked2", 64'(req_o), 64'h0);
            end
        join
        waitDrain();

        $display("[TB] contention ports 0 and 3");
        pushExpected(0, 32'hB0, 2);
        pushExpected(3, 32'hC0, 2);
        fork
            applyStimulus(0, 32'hB0, 2, -1, 0);
            applyStimulus(3, 32'hC0, 2, -1, 0);
            begin
                @(negedge clk);
                checkOutput("ct_req_idle", 64'(req_o), 64'h9);
                @(negedge clk);
                checkOutput("ct_ready_own0", 64'(in_ready), 64'h1);
                @(negedge clk);
                checkOutput("ct_ready_own0_b", 64'(in_ready), 64'h1);
            end
        join
        waitDrain();

        $display("[TB] backpressure on port 1");
        pushExpected(1, 32'hD0, 4);
        fork
            applyStimulus(1, 32'hD0, 4, -1, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("bp_ready_low", 64'(in_ready), 64'h0);
                    checkOutput("bp_data_hold", 64'(out_data), 64'hD0);
                    checkOutput("bp_src_hold", 64'(out_src), 64'h1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] owner stall with port 1 waiting");
        pushExpected(0, 32'hE0, 3);
        pushExpected(1, 32'hF0, 1);
        fork
            applyStimulus(0, 32'hE0, 3, 0, 5);
            applyStimulus(1, 32'hF0, 1, -1, 0);
            begin
                repeat (2) @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("st_req", 64'(req_o), 64'h0);
                    checkOutput("st_ready", 64'(in_ready), 64'h1);
                end
            end
        join
        waitDrain();

        $display("[TB] back-to-back single-beat packets on ports 0 and 1");
        pushExpected(0, 32'h10, 1);
        pushExpected(1, 32'h20, 1);
        fork
            applyStimulus(0, 32'h10, 1, -1, 0);
            applyStimulus(1, 32'h20, 1, -1, 0);
            begin
                @(negedge clk);
                @(negedge clk);
`ifdef ARB_PKT_MUX_B2B_EN
                checkOutput("bb_req_last", 64'(req_o), 64'h2);
`else
                checkOutput("bb_req_last", 64'(req_o), 64'h0);
`endif
                @(negedge clk);
                checkOutput("bb_valid_t2", 64'(out_valid), 64'h1);
                checkOutput("bb_src_t2", 64'(out_src), 64'h0);
                @(negedge clk);
`ifdef ARB_PKT_MUX_B2B_EN
                checkOutput("bb_valid_t3", 64'(out_valid), 64'h1);
                checkOutput("bb_src_t3", 64'(out_src), 64'h1);
`else
                checkOutput("bb_valid_t3", 64'(out_valid), 64'h0);
                @(negedge clk);
                checkOutput("bb_valid_t4", 64'(out_valid), 64'h1);
                checkOutput("bb_src_t4", 64'(out_src), 64'h1);
`endif
            end
        join
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
